// File: rtl/pipe_mem_io_if.sv
// pipe_mem_io_if: MEM-stage bus between the pipeline and the data memory/I/O block.
`default_nettype none

interface pipe_mem_io_if;
  logic        mwmem;
  logic [3:0]  mbe;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;

  modport master (output mwmem, output mbe, output malu, output mb, input mmo);
  modport slave  (input mwmem, input mbe, input malu, input mb, output mmo);
endinterface

`default_nettype wire

// File: rtl/pipe_mem_io.sv
// pipe_mem_io: MEM-stage data RAM plus memory-mapped switch/key/LED/hex/counter I/O page.
`default_nettype none

module pipe_mem_io #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned NUM_HEX    = 6,
  parameter int unsigned NUM_SW     = 10,
  parameter int unsigned NUM_KEY    = 3,
  parameter int unsigned NUM_LED    = 10,
  parameter logic [23:0] IO_PAGE    = 24'hFFFFFF
) (
  input  wire logic                 ram_clock,
  input  wire logic                 resetn,
  pipe_mem_io_if.slave              bus,
  input  wire logic [NUM_SW-1:0]    sw,
  input  wire logic [NUM_KEY-1:0]   key,
  output logic      [7*NUM_HEX-1:0] hex,
  output logic      [NUM_LED-1:0]   led
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_mmo;
  logic [NUM_SW-1:0]     r_sw_s1, r_sw_s2;
  logic [NUM_KEY-1:0]    r_key_s1, r_key_s2;
  logic [NUM_KEY-1:0]    r_edge;
  logic [NUM_LED-1:0]    r_led;
  logic [4:0]            r_dig [NUM_HEX];
  logic [31:0]           r_cnt;

  logic                  w_io_sel;
  logic [DEPTH_LOG2-1:0] w_word;
  logic [5:0]            w_off;
  logic                  w_st_io;
  logic                  w_st_ram;
  logic [NUM_KEY-1:0]    w_key_fall;
  logic [31:0]           w_io_rd;
  logic                  w_unused;

  assign w_io_sel   = (bus.malu[31:8] == IO_PAGE);
  assign w_word     = bus.malu[DEPTH_LOG2+1:2];
  assign w_off      = bus.malu[7:2];
  assign w_st_io    = bus.mwmem & w_io_sel;
  assign w_st_ram   = bus.mwmem & ~w_io_sel;
  // Synchronised key goes 1 -> 0 on this edge: a press.
  assign w_key_fall = r_key_s2 & ~r_key_s1;
  assign w_unused   = ^bus.malu[1:0];

  always_comb begin
    w_io_rd = '0;
    case (w_off)
      6'd0:  w_io_rd[NUM_SW-1:0]  = r_sw_s2;
      6'd1:  w_io_rd[NUM_KEY-1:0] = ~r_key_s2;
      6'd2:  w_io_rd[NUM_KEY-1:0] = r_edge;
      6'd3:  w_io_rd[NUM_LED-1:0] = r_led;
      6'd12: w_io_rd              = r_cnt;
      default: begin
        for (int i = 0; i < int'(NUM_HEX); i++) begin
          if (w_off == 6'(4 + i)) w_io_rd[4:0] = r_dig[i];
        end
      end
    endcase
  end

  // RAM has no reset; a store coinciding with reset is still suppressed.
  always_ff @(posedge ram_clock) begin
    if (resetn && w_st_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mbe[b]) r_mem[w_word][8*b +: 8] <= bus.mb[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      r_mmo    <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_edge   <= '0;
      r_led    <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < int'(NUM_HEX); i++) r_dig[i] <= 5'h10;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;

      // A press on the same edge as its write-1-clear keeps the bit set.
      if (w_st_io && w_off == 6'd2 && bus.mbe[0])
        r_edge <= (r_edge & ~bus.mb[NUM_KEY-1:0]) | w_key_fall;
      else
        r_edge <= r_edge | w_key_fall;

      for (int j = 0; j < int'(NUM_LED); j++) begin
        if (w_st_io && w_off == 6'd3 && bus.mbe[j/8]) r_led[j] <= bus.mb[j];
      end

      for (int i = 0; i < int'(NUM_HEX); i++) begin
        if (w_st_io && bus.mbe[0] && w_off == 6'(4 + i)) r_dig[i] <= bus.mb[4:0];
      end

      if (w_st_io && w_off == 6'd12) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 32'd1;

      r_mmo <= w_io_sel ? w_io_rd : r_mem[w_word];
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar gi = 0; gi < int'(NUM_HEX); gi++) begin : g_hex
    assign hex[7*gi +: 7] = r_dig[gi][4] ? 7'h7F : f_seg(r_dig[gi][3:0]);
  end

  assign led     = r_led;
  assign bus.mmo = r_mmo;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_io.sv
// tb_pipe_mem_io: directed and randomized checks of pipe_mem_io against a behavioural model.
`default_nettype none

module tb_pipe_mem_io;
  localparam int NH = 6;
  localparam int NS = 10;
  localparam int NK = 3;
  localparam int NL = 10;

  logic            ram_clock = 1'b0;
  logic            resetn    = 1'b0;
  logic [NS-1:0]   sw        = '0;
  logic [NK-1:0]   key       = '1;
  logic [7*NH-1:0] hex;
  logic [NL-1:0]   led;

  pipe_mem_io_if bus_if();

  pipe_mem_io #(
    .DEPTH_LOG2(8), .NUM_HEX(NH), .NUM_SW(NS), .NUM_KEY(NK), .NUM_LED(NL),
    .IO_PAGE(24'hFFFFFF)
  ) dut (
    .ram_clock(ram_clock),
    .resetn   (resetn),
    .bus      (bus_if.slave),
    .sw       (sw),
    .key      (key),
    .hex      (hex),
    .led      (led)
  );

  always #5 ram_clock = ~ram_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0]   m_ram [256];
  bit            m_known [256];
  logic [NL-1:0] m_led;
  logic [4:0]    m_dig [NH];
  logic [NK-1:0] m_edge;
  logic [31:0]   m_cnt;
  logic [31:0]   m_mmo;
  bit            m_mmo_ok;
  // raw input samples taken one and two edges ago
  logic [NS-1:0] sw_hist  [2];
  logic [NK-1:0] key_hist [2];
  logic [6:0]    seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    m_led = '0; m_edge = '0; m_cnt = '0; m_mmo = '0; m_mmo_ok = 1'b1;
    for (int i = 0; i < NH; i++) m_dig[i] = 5'h10;
    for (int i = 0; i < 2; i++) begin sw_hist[i] = '0; key_hist[i] = '0; end
  endtask

  function automatic logic [31:0] io_read(input int w);
    logic [31:0] r;
    r = '0;
    if (w == 0)                 r[NS-1:0] = sw_hist[1];
    else if (w == 1)            r[NK-1:0] = ~key_hist[1];
    else if (w == 2)            r[NK-1:0] = m_edge;
    else if (w == 3)            r[NL-1:0] = m_led;
    else if (w == 12)           r = m_cnt;
    else if (w >= 4 && w < 4 + NH) r[4:0] = m_dig[w-4];
    return r;
  endfunction

  function automatic logic [7*NH-1:0] exp_hex();
    logic [7*NH-1:0] h;
    for (int i = 0; i < NH; i++)
      h[7*i +: 7] = m_dig[i][4] ? 7'h7F : seg_tab[m_dig[i][3:0]];
    return h;
  endfunction

  task automatic model_edge();
    bit            io;
    int            wd;
    int            w;
    bit            we;
    logic [NK-1:0] fall;
    io   = (bus_if.malu[31:8] == 24'hFFFFFF);
    wd   = int'(bus_if.malu[9:2]);
    w    = int'(bus_if.malu[7:2]);
    we   = bus_if.mwmem;
    fall = key_hist[1] & ~key_hist[0];
    if (io) begin m_mmo = io_read(w); m_mmo_ok = 1'b1; end
    else    begin m_mmo = m_ram[wd];  m_mmo_ok = m_known[wd]; end
    if (we && !io) begin
      for (int b = 0; b < 4; b++)
        if (bus_if.mbe[b]) m_ram[wd][8*b +: 8] = bus_if.mb[8*b +: 8];
      if (bus_if.mbe == 4'hF) m_known[wd] = 1'b1;
    end
    if (we && io && w == 2 && bus_if.mbe[0]) m_edge = m_edge & ~bus_if.mb[NK-1:0];
    m_edge = m_edge | fall;
    if (we && io && w == 3)
      for (int j = 0; j < NL; j++) if (bus_if.mbe[j/8]) m_led[j] = bus_if.mb[j];
    if (we && io && bus_if.mbe[0] && w >= 4 && w < 4 + NH) m_dig[w-4] = bus_if.mb[4:0];
    m_cnt = (we && io && w == 12) ? 32'd0 : m_cnt + 32'd1;
    sw_hist[1]  = sw_hist[0];  sw_hist[0]  = sw;
    key_hist[1] = key_hist[0]; key_hist[0] = key;
  endtask

  // Drive one bus cycle from a negedge, let the posedge take it, check at the next negedge.
  task automatic step(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    bus_if.mwmem = we; bus_if.mbe = be; bus_if.malu = a; bus_if.mb = d;
    @(posedge ram_clock);
    model_edge();
    @(negedge ram_clock);
    if (m_mmo_ok) check("mmo", {32'd0, bus_if.mmo}, {32'd0, m_mmo});
    check("led", {54'd0, led}, {54'd0, m_led});
    check("hex", {22'd0, hex}, {22'd0, exp_hex()});
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b0, 4'h0, a, 32'h0);
  endtask

  logic [31:0] v1;
  logic [31:0] ra, rd;

  initial begin
    bus_if.mwmem = 1'b0; bus_if.mbe = 4'h0; bus_if.malu = '0; bus_if.mb = '0;
    for (int i = 0; i < 256; i++) begin m_ram[i] = '0; m_known[i] = 1'b0; end
    model_reset();
    repeat (3) @(negedge ram_clock);
    check("rst_mmo", {32'd0, bus_if.mmo}, 64'd0);
    check("rst_led", {54'd0, led}, 64'd0);
    check("rst_hex", {22'd0, hex}, {22'd0, {NH{7'h7F}}});
    resetn = 1'b1;

    load(32'hFFFFFF30);
    v1 = bus_if.mmo;
    load(32'hFFFFFF30);
    check("cnt_inc", {32'd0, bus_if.mmo}, {32'd0, v1 + 32'd1});

    for (int i = 0; i < 256; i++) step(1'b1, 4'hF, 32'(i * 4), $urandom);

    step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1'b1, 4'b0010, 32'h10, 32'h0000AA00);
    load(32'h10);
    check("ram_merge", {32'd0, bus_if.mmo}, {32'd0, 32'hDEADAAEF});
    load(32'h410);
    check("ram_alias", {32'd0, bus_if.mmo}, {32'd0, 32'hDEADAAEF});

    step(1'b1, 4'hF, 32'hFFFFFF10, 32'h7);
    check("hex_7", {57'd0, hex[6:0]}, {57'd0, 7'h78});
    step(1'b1, 4'hF, 32'hFFFFFF10, 32'h10);
    check("hex_blank", {57'd0, hex[6:0]}, {57'd0, 7'h7F});
    load(32'hFFFFFF10);
    check("dig_read", {32'd0, bus_if.mmo}, {32'd0, 32'h10});

    key = 3'b101;
    load(32'hFFFFFF08); load(32'hFFFFFF08); load(32'hFFFFFF08);
    check("key_edge", {32'd0, bus_if.mmo}, {32'd0, 32'h2});
    step(1'b1, 4'h1, 32'hFFFFFF08, 32'h2);
    load(32'hFFFFFF08);
    check("edge_clr", {32'd0, bus_if.mmo}, 64'd0);
    key = 3'b111;
    load(32'hFFFFFF04); load(32'hFFFFFF04); load(32'hFFFFFF04);
    key = 3'b101;
    load(32'hFFFFFF08);
    step(1'b1, 4'h1, 32'hFFFFFF08, 32'h2);
    load(32'hFFFFFF08);
    check("set_wins", {32'd0, bus_if.mmo}, {32'd0, 32'h2});
    key = 3'b111;

    sw = 10'h2A5;
    load(32'hFFFFFF00); load(32'hFFFFFF00); load(32'hFFFFFF00);
    check("sw_sync", {32'd0, bus_if.mmo}, {32'd0, 32'h2A5});
    step(1'b1, 4'b0001, 32'hFFFFFF0C, 32'h3FF);
    check("led_lane", {54'd0, led}, {54'd0, 10'h0FF});

    step(1'b1, 4'h0, 32'hFFFFFF30, 32'h0);
    load(32'hFFFFFF30);
    check("cnt_clr", {32'd0, bus_if.mmo}, 64'd0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) sw  = NS'($urandom);
      if ($urandom_range(0, 3) == 0) key = NK'($urandom);
      if ($urandom_range(0, 1) == 1) ra = {24'hFFFFFF, 4'h0, 4'($urandom_range(0, 15))} | 32'($urandom_range(0, 3) << 4) & 32'hFFFFFF30 | 32'($urandom_range(0, 3));
      else                           ra = $urandom;
      rd = $urandom;
      step($urandom_range(0, 2) == 0, 4'($urandom), ra, rd);
    end

    step(1'b1, 4'hF, 32'hFFFFFF0C, 32'h2AA);
    bus_if.mwmem = 1'b1; bus_if.mbe = 4'hF; bus_if.malu = 32'hFFFFFF0C; bus_if.mb = 32'h3FF;
    #2 resetn = 1'b0;
    model_reset();
    @(posedge ram_clock);
    @(negedge ram_clock);
    check("rst_mid_led", {54'd0, led}, 64'd0);
    check("rst_mid_mmo", {32'd0, bus_if.mmo}, 64'd0);
    check("rst_mid_hex", {22'd0, hex}, {22'd0, {NH{7'h7F}}});
    resetn = 1'b1;
    load(32'h10);
    check("ram_kept", {32'd0, bus_if.mmo}, {32'd0, m_ram[4]});
    load(32'hFFFFFF0C);
    check("led_read", {32'd0, bus_if.mmo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
